// File: rtl/interrupt_controller.sv
// Interrupt controller: per-channel edge capture into IF, IE masking,
// IME with delayed EI, and an IDLE/REQUEST/SERVICE dispatch handshake
// that latches the handler vector of the lowest pending channel.

// One interrupt channel: edge detector, flag bit and enable bit.
module irq_channel (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_Irq,
  input  logic i_Write_IF,
  input  logic i_Write_IE,
  input  logic i_Wdata,
  input  logic i_Ack_Clear,
  output logic o_IF,
  output logic o_IE,
  output logic o_Pend_Next
);

  logic prev_q, prev_d;
  logic if_q, if_d;
  logic ie_q, ie_d;
  logic edge_det;

  // Next-state for the channel; a fresh edge beats any clear in the same cycle.
  always_comb begin
    edge_det = i_Irq & ~prev_q;
    prev_d   = i_Irq;
    if_d     = ((i_Write_IF ? i_Wdata : if_q) & ~i_Ack_Clear) | edge_det;
    ie_d     = i_Write_IE ? i_Wdata : ie_q;
  end

  // Channel registers; reset samples the live source so a held line is not an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      prev_q <= i_Irq;
      if_q   <= 1'b0;
      ie_q   <= 1'b0;
    end else if (i_Enable) begin
      prev_q <= prev_d;
      if_q   <= if_d;
      ie_q   <= ie_d;
    end
  end

  assign o_IF        = if_q;
  assign o_IE        = ie_q;
  assign o_Pend_Next = if_d & ie_d;

endmodule

module interrupt_controller #(
  parameter int              NUM_IRQ       = 5,
  parameter logic [15:0]     VECTOR_BASE   = 16'h0040,
  parameter int              VECTOR_STRIDE = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  input  logic [NUM_IRQ-1:0] i_Irq,
  input  logic               i_Write_IF,
  input  logic               i_Write_IE,
  input  logic [NUM_IRQ-1:0] i_Wdata,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Instr_Done,
  input  logic               i_Ack,
  input  logic               i_Service_Done,
  output logic [NUM_IRQ-1:0] o_IF,
  output logic [NUM_IRQ-1:0] o_IE,
  output logic               o_IME,
  output logic               o_Irq_Req,
  output logic               o_In_Service,
  output logic               o_Wake,
  output logic [15:0]        o_Vector
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_SERVICE} state_t;

  state_t             state_q, state_d;
  logic               ime_q, ime_d;
  logic               ei_armed_q, ei_armed_d;
  logic               irq_req_q, irq_req_d;
  logic               in_service_q, in_service_d;
  logic [15:0]        vector_q, vector_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [4:0]         sel_idx;
  logic               ack_fire;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_ch
      irq_channel u_ch (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Enable    (i_Enable),
        .i_Irq       (i_Irq[g]),
        .i_Write_IF  (i_Write_IF),
        .i_Write_IE  (i_Write_IE),
        .i_Wdata     (i_Wdata[g]),
        .i_Ack_Clear (ack_clear[g]),
        .o_IF        (o_IF[g]),
        .o_IE        (o_IE[g]),
        .o_Pend_Next (pend_next[g])
      );
    end
  endgenerate

  // Pending set and lowest-index selection; ack_clear is the isolated lowest bit.
  always_comb begin
    pending  = o_IF & o_IE;
    sel_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = i[4:0];
    end
    ack_fire  = (state_q == ST_REQUEST) && i_Ack && ime_q && (|pending);
    ack_clear = ack_fire ? (pending & (~pending + NUM_IRQ'(1))) : '0;
  end

  // IME / EI arming and dispatch FSM next-state; DI has the last word.
  always_comb begin
    ime_d      = ime_q;
    ei_armed_d = ei_armed_q;
    state_d    = state_q;
    vector_d   = vector_q;

    if (ei_armed_q && i_Instr_Done) begin
      ime_d      = 1'b1;
      ei_armed_d = 1'b0;
    end
    if (i_EI)   ei_armed_d = 1'b1;
    if (i_RETI) ime_d      = 1'b1;
    if (ack_fire) begin
      ime_d      = 1'b0;
      ei_armed_d = 1'b0;
      vector_d   = VECTOR_BASE + 16'(sel_idx) * 16'(VECTOR_STRIDE);
    end
    if (i_DI) begin
      ime_d      = 1'b0;
      ei_armed_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:    if (ime_q && (|pending)) state_d = ST_REQUEST;
      // Withdraw looks at next-cycle IF/IE/IME so the request drops right away.
      ST_REQUEST: if (ack_fire)                          state_d = ST_SERVICE;
                  else if (!ime_d || (pend_next == '0))  state_d = ST_IDLE;
      ST_SERVICE: if (i_Service_Done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    irq_req_d    = (state_d == ST_REQUEST);
    in_service_d = (state_d == ST_SERVICE);
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      ime_q        <= 1'b0;
      ei_armed_q   <= 1'b0;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      vector_q     <= VECTOR_BASE;
    end else if (i_Enable) begin
      state_q      <= state_d;
      ime_q        <= ime_d;
      ei_armed_q   <= ei_armed_d;
      irq_req_q    <= irq_req_d;
      in_service_q <= in_service_d;
      vector_q     <= vector_d;
    end
  end

  assign o_IME        = ime_q;
  assign o_Irq_Req    = irq_req_q;
  assign o_In_Service = in_service_q;
  assign o_Vector     = vector_q;
  assign o_Wake       = |pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [4:0] irq, wdata;
  logic       wr_if, wr_ie, ei, di, reti, idone, ack, sdone;
  logic [4:0] o_if, o_ie;
  logic       ime, req, insvc, wake;
  logic [15:0] vec;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_IRQ(5), .VECTOR_BASE(16'h0040), .VECTOR_STRIDE(8)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Irq(irq),
    .i_Write_IF(wr_if), .i_Write_IE(wr_ie), .i_Wdata(wdata),
    .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Instr_Done(idone),
    .i_Ack(ack), .i_Service_Done(sdone),
    .o_IF(o_if), .o_IE(o_ie), .o_IME(ime), .o_Irq_Req(req),
    .o_In_Service(insvc), .o_Wake(wake), .o_Vector(vec)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; irq = '0; wdata = '0;
    wr_if = 0; wr_ie = 0; ei = 0; di = 0; reti = 0; idone = 0; ack = 0; sdone = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_if", 32'(o_if), 0);
    chk("rst_ie", 32'(o_ie), 0);
    chk("rst_ime", 32'(ime), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_svc", 32'(insvc), 0);
    chk("rst_vec", 32'(vec), 32'h40);
    chk("rst_wake", 32'(wake), 0);

    // Wake with IME=0
    wr_ie = 1; wdata = 5'b01000; tick(); wr_ie = 0;
    chk("wake_ie", 32'(o_ie), 32'b01000);
    irq = 5'b01000; tick();
    chk("wake_if", 32'(o_if), 32'b01000);
    chk("wake_wake", 32'(wake), 1);
    tick();
    chk("wake_noreq", 32'(req), 0);
    irq = '0; wr_if = 1; wdata = '0; tick(); wr_if = 0;
    chk("wake_clr", 32'(o_if), 0);

    // Clock enable low freezes everything
    en = 0; irq = 5'b00001; tick(); tick();
    chk("en_frozen", 32'(o_if), 0);
    en = 1; tick();
    chk("en_edge", 32'(o_if), 32'b00001);
    irq = '0; wr_if = 1; wdata = '0; tick(); wr_if = 0;

    // Priority: edges on 2 and 4
    wr_ie = 1; wdata = 5'b11111; tick(); wr_ie = 0;
    reti = 1; tick(); reti = 0;
    chk("pri_ime", 32'(ime), 1);
    irq = 5'b10100; tick();
    chk("pri_if", 32'(o_if), 32'b10100);
    chk("pri_req0", 32'(req), 0);
    tick();
    chk("pri_req1", 32'(req), 1);
    ack = 1; tick(); ack = 0;
    chk("pri_vec", 32'(vec), 32'h50);
    chk("pri_if_ack", 32'(o_if), 32'b10000);
    chk("pri_ime0", 32'(ime), 0);
    chk("pri_svc", 32'(insvc), 1);
    chk("pri_req_drop", 32'(req), 0);
    sdone = 1; tick(); sdone = 0;
    chk("pri_done", 32'(insvc), 0);
    tick();
    chk("pri_no_redispatch", 32'(req), 0);
    irq = '0; wr_if = 1; wdata = '0; tick(); wr_if = 0;

    // EI delay
    irq = 5'b00001; tick();
    ei = 1; tick(); ei = 0;
    chk("ei_arm_ime", 32'(ime), 0);
    tick();
    chk("ei_wait1", 32'(req), 0);
    tick();
    chk("ei_wait2", 32'(req), 0);
    idone = 1; tick(); idone = 0;
    chk("ei_ime1", 32'(ime), 1);
    chk("ei_req_still0", 32'(req), 0);
    tick();
    chk("ei_req1", 32'(req), 1);
    ack = 1; tick(); ack = 0;
    chk("ei_vec", 32'(vec), 32'h40);
    chk("ei_if", 32'(o_if), 0);
    sdone = 1; tick(); sdone = 0;
    irq = '0; tick();

    // Withdraw
    reti = 1; tick(); reti = 0;
    irq = 5'b00010; tick(); tick();
    chk("wd_req1", 32'(req), 1);
    wr_if = 1; wdata = '0; tick(); wr_if = 0;
    chk("wd_req0", 32'(req), 0);
    chk("wd_if", 32'(o_if), 0);
    ack = 1; tick(); ack = 0;
    chk("wd_ack_svc", 32'(insvc), 0);
    chk("wd_ack_ime", 32'(ime), 1);
    chk("wd_ack_vec", 32'(vec), 32'h40);

    // Collision: ack on bit 1 with a new edge on bit 1
    irq = 5'b00000; tick();
    irq = 5'b00010; tick(); tick();
    chk("col_req", 32'(req), 1);
    irq = 5'b00000; tick();
    chk("col_hold_req", 32'(req), 1);
    irq = 5'b00010; ack = 1; tick(); ack = 0;
    chk("col_if", 32'(o_if), 32'b00010);
    chk("col_ime", 32'(ime), 0);
    chk("col_svc", 32'(insvc), 1);
    chk("col_vec", 32'(vec), 32'h48);
    sdone = 1; tick(); sdone = 0;
    irq = '0; wr_if = 1; wdata = '0; tick(); wr_if = 0;

    // Reset mid-SERVICE with a source held high
    reti = 1; tick(); reti = 0;
    irq = 5'b00100; tick(); tick();
    ack = 1; tick(); ack = 0;
    chk("rs_vec", 32'(vec), 32'h50);
    irq = 5'b00001; tick();
    chk("rs_svc", 32'(insvc), 1);
    chk("rs_wake_pre", 32'(wake), 1);
    rst = 1; en = 0; tick();
    chk("rs_if", 32'(o_if), 0);
    chk("rs_ie", 32'(o_ie), 0);
    chk("rs_ime", 32'(ime), 0);
    chk("rs_svc0", 32'(insvc), 0);
    chk("rs_req0", 32'(req), 0);
    chk("rs_vec0", 32'(vec), 32'h40);
    chk("rs_wake0", 32'(wake), 0);
    rst = 0; en = 1; tick(); tick();
    chk("rs_no_edge", 32'(o_if), 0);
    chk("rs_wake_after", 32'(wake), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
